// File: rtl/ysyx_22040895_ifq.sv
// Instruction-fetch queue: owns the fetch PC, issues one imem request at a time,
// buffers {pc, inst} pairs in a DEPTH-entry FIFO and hands them to decode.
module ysyx_22040895_ifq #(
  parameter int                 ADDR_W   = 64,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  output logic                         imem_req_valid_o,
  output logic [ADDR_W-1:0]            imem_req_addr_o,
  input  logic                         imem_req_ready_i,
  input  logic                         imem_resp_valid_i,
  input  logic [INST_W-1:0]            imem_resp_inst_i,
  output logic                         inst_valid_o,
  output logic [INST_W-1:0]            inst_o,
  output logic [ADDR_W-1:0]            pc_o,
  input  logic                         inst_ready_i,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              outstanding;
  logic              drop;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [CNT_W:0]    in_flight;
  logic              req_fire;
  logic              resp_take;
  logic              push;
  logic              pop;

  // An outstanding request already owns a slot, so it is counted against capacity.
  assign in_flight = {1'b0, count} + (CNT_W+1)'(outstanding);

  assign imem_req_valid_o = !rst && (!outstanding || imem_resp_valid_i) &&
                            (in_flight < (CNT_W+1)'(DEPTH)) && !redirect_i;
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign resp_take = imem_resp_valid_i && outstanding;
  assign push      = resp_take && !drop && !redirect_i;
  assign pop       = inst_valid_o && inst_ready_i && !redirect_i;

  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : '0;
  assign pc_o         = inst_valid_o ? pc_mem[rd_ptr]   : '0;
  assign count_o      = count;

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
      // A response in the redirect cycle retires the stale request on the spot;
      // otherwise the late response must be swallowed when it shows up.
      if (outstanding) begin
        if (imem_resp_valid_i) begin
          outstanding <= 1'b0;
          drop        <= 1'b0;
        end else begin
          drop <= 1'b1;
        end
      end
    end else begin
      if (req_fire) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (resp_take) drop <= 1'b0;
      if (req_fire)       outstanding <= 1'b1;
      else if (resp_take) outstanding <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left unreset; the outputs are gated
  // by inst_valid_o, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_resp_inst_i;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_ifq.sv
// Directed bench for ysyx_22040895_ifq: table-driven stream/full vectors plus
// hand-written redirect, backpressure and mid-run reset sequences.
module tb_ysyx_22040895_ifq;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [63:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_inst_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_ready_i;
  logic [2:0]  count_o;

  int total  = 0;
  int passed = 0;
  bit auto_mem = 1'b1;

  ysyx_22040895_ifq dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_inst_i  (imem_resp_inst_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .pc_o              (pc_o),
    .inst_ready_i      (inst_ready_i),
    .count_o           (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {a[31:2], 2'b11} ^ 32'h00a0_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: the memory model answers an accepted request on the next cycle.
  task automatic step();
    logic        fire;
    logic [63:0] a;
    #1;
    fire = imem_req_valid_o && imem_req_ready_i;
    a    = imem_req_addr_o;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_resp_valid_i = fire;
      imem_resp_inst_i  = inst_of(a);
    end
    #1;
  endtask

  typedef struct {
    logic        req_ready;
    logic        inst_ready;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic [63:0] exp_pc;
    int          exp_count;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'h0,          0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0000, 1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 64'h8000_000c, 1'b1, 64'h8000_0004, 1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0008, 1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 64'h8000_0014, 1'b1, 64'h8000_0008, 2};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0018, 1'b1, 64'h8000_0008, 3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0018, 1'b1, 64'h8000_0008, 4};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0018, 1'b1, 64'h8000_0008, 4};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0018, 1'b1, 64'h8000_000c, 3};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 64'h8000_001c, 1'b1, 64'h8000_000c, 3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 64'h8000_001c, 1'b1, 64'h8000_000c, 4};

    rst = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_req_ready_i = 1'b1;
    imem_resp_valid_i = 1'b0;
    imem_resp_inst_i = '0;
    inst_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    check("rst_req_valid", imem_req_valid_o, 0);
    check("rst_inst_valid", inst_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", pc_o, 0);
    rst = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid_o, 1);
    check("first_req_addr", imem_req_addr_o, 64'h8000_0000);

    // Streaming with zero-wait memory, then decode stall fills the queue.
    for (int i = 0; i < 11; i++) begin
      imem_req_ready_i = vecs[i].req_ready;
      inst_ready_i     = vecs[i].inst_ready;
      step();
      check($sformatf("v%0d_req_valid", i), imem_req_valid_o, vecs[i].exp_rv);
      check($sformatf("v%0d_req_addr", i), imem_req_addr_o, vecs[i].exp_addr);
      check($sformatf("v%0d_inst_valid", i), inst_valid_o, vecs[i].exp_iv);
      check($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
      check($sformatf("v%0d_inst", i), inst_o,
            vecs[i].exp_iv ? {32'h0, inst_of(vecs[i].exp_pc)} : 64'h0);
      check($sformatf("v%0d_count", i), count_o, 64'(vecs[i].exp_count));
    end

    // Redirect while a response and a pop happen in the same cycle.
    inst_ready_i = 1'b1;
    step();
    step();
    check("rsp_pre_resp_valid", imem_resp_valid_i, 1);
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_2000;
    #1;
    check("rsp_redirect_blocks_req", imem_req_valid_o, 0);
    step();
    redirect_i = 1'b0;
    #1;
    check("rsp_count", count_o, 0);
    check("rsp_inst_valid", inst_valid_o, 0);
    check("rsp_req_valid", imem_req_valid_o, 1);
    check("rsp_req_addr", imem_req_addr_o, 64'h8000_2000);
    step();
    step();
    check("rsp_new_pc", pc_o, 64'h8000_2000);
    check("rsp_new_count", count_o, 1);

    // Redirect with a request outstanding and no response yet.
    imem_req_ready_i = 1'b0;
    step();
    auto_mem = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0010;
    step();
    redirect_i = 1'b0;
    #1;
    check("out_req_addr", imem_req_addr_o, 64'h8000_0010);
    check("out_count", count_o, 0);
    step();
    check("out_wait_valid", imem_req_valid_o, 0);
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_1002;
    #1;
    check("out_redirect_valid", imem_req_valid_o, 0);
    step();
    redirect_i = 1'b0;
    #1;
    check("out_drop_wait_valid", imem_req_valid_o, 0);
    check("out_aligned_addr", imem_req_addr_o, 64'h8000_1000);
    imem_resp_valid_i = 1'b1;
    imem_resp_inst_i = 32'hdead_beef;
    #1;
    check("out_stale_resp_req_valid", imem_req_valid_o, 1);
    step();
    check("out_stale_dropped", inst_valid_o, 0);
    imem_resp_inst_i = inst_of(64'h8000_1000);
    imem_req_ready_i = 1'b0;
    step();
    imem_resp_valid_i = 1'b0;
    inst_ready_i = 1'b0;
    #1;
    check("out_new_valid", inst_valid_o, 1);
    check("out_new_pc", pc_o, 64'h8000_1000);
    check("out_new_inst", inst_o, inst_of(64'h8000_1000));
    check("out_new_count", count_o, 1);

    // Backpressure: request held with a stable address.
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp%0d_valid", i), imem_req_valid_o, 1);
      check($sformatf("bp%0d_addr", i), imem_req_addr_o, 64'h8000_1004);
    end
    imem_req_ready_i = 1'b1;
    auto_mem = 1'b1;
    step();
    check("bp_accept_addr", imem_req_addr_o, 64'h8000_1008);

    // Asynchronous reset mid-run with three entries held.
    for (int i = 0; i < 20 && count_o != 3'd3; i++) step();
    check("fill3_count", count_o, 3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", imem_req_valid_o, 0);
    check("mid_rst_inst_valid", inst_valid_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_inst", inst_o, 0);
    check("mid_rst_pc", pc_o, 0);
    auto_mem = 1'b0;
    imem_resp_valid_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_valid", imem_req_valid_o, 1);
    check("post_rst_addr", imem_req_addr_o, 64'h8000_0000);
    step();
    check("post_rst_fire_addr", imem_req_addr_o, 64'h8000_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_ifq.md
# ysyx_22040895_ifq

Parametrised instruction-fetch queue: the multi-cycle successor to the single-cycle fetch path, placed between the PC/imem interface and the decode stage. Owns the fetch PC, issues instruction-memory requests over a valid/ready handshake, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode with valid/ready. A redirect from execute (jump/branch) flushes the queue and drops any in-flight response.

## Interface
- ADDR_W, 64, PC / instruction address width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect_i  in  1  flush queue and restart fetch at redirect_pc_i
- redirect_pc_i  in  ADDR_W  new fetch PC; bits [1:0] ignored (forced 0)
- imem_req_valid_o  out  1  fetch request valid
- imem_req_addr_o  out  ADDR_W  fetch address (= fetch PC)
- imem_req_ready_i  in  1  memory accepts request
- imem_resp_valid_i  in  1  response valid (always accepted)
- imem_resp_inst_i  in  INST_W  returned instruction
- inst_valid_o  out  1  queue head valid
- inst_o  out  INST_W  head instruction
- pc_o  out  ADDR_W  head PC
- inst_ready_i  in  1  decode consumes head
- count_o  out  $clog2(DEPTH)+1  entries held

## Operation
- State: fetch_pc, outstanding (0/1), req_pc (PC of outstanding request), drop flag, FIFO (rd/wr pointers, count).
- Request: imem_req_valid_o = (!outstanding || imem_resp_valid_i) && (count + outstanding < DEPTH) && !redirect_i. Combinational on imem_resp_valid_i. Pop in same cycle not credited.
- Request fire (valid && ready): req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (mod 2^ADDR_W); outstanding <= 1.
- Response while outstanding: if !drop, push {req_pc, imem_resp_inst_i}; drop <= 0; outstanding <= 0 unless a new request fires same cycle.
- Response while !outstanding: ignored, no state change.
- Pop: inst_valid_o && inst_ready_i removes head. Push and pop same cycle: count unchanged.
- Redirect (highest priority): count, pointers <= 0; fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}; no request issued that cycle; any push/pop that cycle discarded. If outstanding and no response in this cycle, drop <= 1; response arriving in the redirect cycle is discarded and clears outstanding.
- Memory must not withdraw ready semantics: request held with stable address until accepted, except when redirect_i deasserts it.

## Timing
- Reset values: imem_req_valid_o 0 during rst; inst_valid_o 0, count_o 0, inst_o/pc_o 0, fetch_pc RESET_PC, outstanding 0, drop 0.
- First request may fire the cycle after rst deasserts.
- Latency: request accepted cycle N, response earliest N+1, inst_valid_o high N+2 (queue registered, no bypass).
- Throughput: with zero-wait memory (ready=1, resp next cycle) one instruction per cycle steady state.
- Full: count + outstanding == DEPTH blocks issue; resumes the cycle after a pop.
- Redirect: first post-redirect request at cycle R+1 (if not still outstanding); stale response at any cycle while drop=1 never enters queue.

## Test plan
- Reset: rst high mid-run with 3 entries -> all outputs 0 immediately, first req addr 0x8000_0000 after release.
- Stream: ready=1, 1-cycle memory, decode ready -> pc_o 0x80000000, 0x80000004, 0x80000008… on consecutive cycles from cycle 3.
- Full: decode ready=0, DEPTH=4 -> exactly 4 requests, count_o=4, req_valid 0; one pop -> one new request next cycle.
- Redirect with outstanding: request 0x80000010 accepted, redirect to 0x80001002 before response -> response dropped, next req addr 0x80001000, pc_o 0x80001000.
- Redirect with simultaneous response and pop -> queue empty next cycle, count_o 0, response discarded.
- Backpressure: req_ready=0 for 5 cycles -> imem_req_valid_o held 1, addr stable, fetch_pc unchanged.
